// File: rtl/uart_tx_arb.sv
// Round-robin arbiter between two byte sources owning the full UART tx handshake.
// Optional counters and ack trace are enabled with UART_TX_ARB_STATS_EN.
module uart_tx_arb #(
  parameter int TIMEOUT   = 1024,
  parameter int CW        = 11,
  parameter int DRAIN_MIN = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_ack,
  input  logic       tx_empty,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout
`ifdef UART_TX_ARB_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
  output logic [7:0]  to_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int DW = (DRAIN_MIN > 1) ? $clog2(DRAIN_MIN + 1) : 1;

  logic [1:0]    r_state;
  logic          r_last;
  logic [7:0]    r_hold;
  logic [1:0]    r_grant;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dcnt;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_to;

  logic w_start;
  logic w_pick1;
  logic w_to_hit;

  // On a tie r_last names the previous owner, so the other side wins.
  assign w_start  = tx_empty & (req0 | req1);
  assign w_pick1  = req1 & (~req0 | ~r_last);
  assign w_to_hit = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_hold  <= 8'd0;
      r_grant <= 2'b00;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_to   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_hold  <= w_pick1 ? data1 : data0;
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // An ack landing on the limit cycle still counts as delivered.
          if (tx_ack) begin
            r_ack0  <= r_grant[0];
            r_ack1  <= r_grant[1];
            r_last  <= r_grant[1];
            r_dcnt  <= '0;
            r_state <= S_DRAIN;
          end else if (w_to_hit) begin
            r_to    <= 1'b1;
            r_last  <= r_grant[1];
            r_grant <= 2'b00;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          // tx_empty can lag tx_ack, so it is ignored for the first cycles.
          if (r_dcnt < DW'(DRAIN_MIN - 1)) begin
            r_dcnt <= r_dcnt + DW'(1);
          end else if (tx_empty) begin
            r_grant <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_grant <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_req  = (r_state == S_ISSUE);
  assign tx_data = r_hold;
  assign grant   = r_grant;
  assign busy    = (r_state != S_IDLE);
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign timeout = r_to;

`ifdef UART_TX_ARB_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;
  logic [7:0]  r_tocnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0  <= 16'd0;
      r_cnt1  <= 16'd0;
      r_tocnt <= 8'd0;
    end else begin
      if (r_ack0) r_cnt0 <= r_cnt0 + 16'd1;
      if (r_ack1) r_cnt1 <= r_cnt1 + 16'd1;
      if (r_to && (r_tocnt != 8'hFF)) r_tocnt <= r_tocnt + 8'd1;
    end
  end

  assign cnt0   = r_cnt0;
  assign cnt1   = r_cnt1;
  assign to_cnt = r_tocnt;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (r_ack0 || r_ack1) $display("uart_tx_arb: owner=%0d byte=%03o", r_ack1, r_hold);
  end
`endif
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: UART model, per-ack scoreboard and directed arbitration cases.
module tb_uart_tx_arb;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'd0, data1 = 8'd0;
  logic       ack0, ack1, tx_req, busy, timeout;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       tx_ack = 1'b0;
  logic       tx_empty = 1'b1;
`ifdef UART_TX_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;
  logic [7:0]  to_cnt;
`endif

  int n_chk = 0, n_pass = 0;
  int n_acks = 0, n_to = 0;
  bit ack_en = 1'b0;
  int empty_hold = 0;
  int bcnt = 0;
  bit ack_pend = 1'b0;
  logic [7:0] cap_data = 8'd0;
  logic [9:0] sb[$];

  uart_tx_arb #(.TIMEOUT(16), .CW(5), .DRAIN_MIN(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .tx_empty(tx_empty),
    .grant(grant), .busy(busy), .timeout(timeout)
`ifdef UART_TX_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .to_cnt(to_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Scoreboard check of ack pulses, then a UART that acks one cycle after tx_req.
  always @(negedge clk) begin
    if (ack_pend) begin
      logic [9:0] e;
      ack_pend = 1'b0;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_owner", {ack1, ack0}, e[9:8]);
        chk("ack_grant", grant, e[9:8]);
        chk("ack_data", cap_data, e[7:0]);
      end
      n_acks++;
    end else if (ack0 || ack1) begin
      chk("spurious_ack", {ack1, ack0}, 2'b00);
    end
    if (timeout) n_to++;
    if (!reset_n) begin
      tx_ack = 1'b0;
      bcnt = 0;
    end else if (tx_ack) begin
      tx_ack = 1'b0;
      bcnt = empty_hold;
    end else if (ack_en && tx_req) begin
      tx_ack = 1'b1;
      cap_data = tx_data;
      ack_pend = 1'b1;
    end
    if (bcnt > 0) begin
      tx_empty = 1'b0;
      bcnt--;
    end else begin
      tx_empty = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input string tag);
    int k = 0;
    while (n_acks < target && k < 300) begin step(); k++; end
    chk(tag, n_acks, target);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin step(); k++; end
    chk(tag, busy, 0);
  endtask

  initial begin
    int cnt, gap, lowcnt;
    bit seen_low;
    // Reset values, with both requesters already pending for the tie case.
    req0 = 1'b1; data0 = "A";
    req1 = 1'b1; data1 = "B";
    #12;
    chk("rst_tx_req", tx_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tx_data", tx_data, 0);

    // Tie from reset: A,B,A,B.
    ack_en = 1'b1; empty_hold = 0;
    sb.push_back({2'b01, 8'h41}); sb.push_back({2'b10, 8'h42});
    sb.push_back({2'b01, 8'h41}); sb.push_back({2'b10, 8'h42});
    step();
    reset_n = 1'b1;
    step();
    chk("tie_first_grant", grant, 2'b01);
    wait_acks(4, "tie_acks");
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("tie_idle");

    // Single requester, one cycle latency.
    req0 = 1'b1; data0 = 8'o215;
    sb.push_back({2'b01, 8'o215});
    chk("single_pre_req", tx_req, 0);
    step();
    chk("single_tx_req", tx_req, 1);
    chk("single_tx_data", tx_data, 8'o215);
    chk("single_grant", grant, 2'b01);
    wait_acks(5, "single_acks");
    chk("single_drain_grant", grant, 2'b01);
    req0 = 1'b0;
    wait_idle("single_idle");
    chk("single_grant_idle", grant, 2'b00);

    // Long drain: next byte waits for tx_empty.
    empty_hold = 38;
    req1 = 1'b1; data1 = 8'h5A;
    sb.push_back({2'b10, 8'h5A});
    wait_acks(6, "drain_acks");
    req1 = 1'b0;
    req0 = 1'b1; data0 = 8'h33;
    sb.push_back({2'b01, 8'h33});
    cnt = 0; gap = 0; lowcnt = 0; seen_low = 1'b0;
    while (!tx_req && cnt < 100) begin
      step(); cnt++;
      if (!tx_empty) begin seen_low = 1'b1; lowcnt++; end
      else if (seen_low && !tx_req) gap++;
    end
    empty_hold = 0;
    chk("drain_req_seen", tx_req, 1);
    chk("drain_low_long", 32'(lowcnt >= 30), 1);
    chk("drain_gap", gap, 1);
    wait_acks(7, "drain_acks2");
    req0 = 1'b0;
    wait_idle("drain_idle");

    // Minimum drain with tx_empty always high.
    req1 = 1'b1; data1 = 8'h5C;
    sb.push_back({2'b10, 8'h5C});
    cnt = 0;
    while (!ack1 && cnt < 50) begin step(); cnt++; end
    chk("min_ack1", ack1, 1);
    req1 = 1'b0;
    chk("min_busy0", busy, 1);
    chk("min_txreq0", tx_req, 0);
    step();
    chk("min_busy1", busy, 1);
    chk("min_grant1", grant, 2'b10);
    step();
    chk("min_busy2", busy, 0);
    chk("min_grant2", grant, 2'b00);

    // Timeout on requester 1, then pending requester 0 wins.
    ack_en = 1'b0;
    req1 = 1'b1; data1 = 8'h77;
    cnt = 0;
    while (!tx_req && cnt < 20) begin step(); cnt++; end
    req0 = 1'b1; data0 = 8'h11;
    cnt = 1;
    step();
    while (tx_req && cnt < 100) begin cnt++; step(); end
    chk("to_issue_cycles", cnt, 16);
    chk("to_pulse", timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_grant", grant, 2'b00);
    ack_en = 1'b1;
    sb.push_back({2'b01, 8'h11}); sb.push_back({2'b10, 8'h77});
    step();
    chk("to_pulse_len", timeout, 0);
    chk("to_next_grant", grant, 2'b01);
    chk("to_next_data", tx_data, 8'h11);
    wait_acks(10, "to_acks");
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("to_idle");
    chk("to_count", n_to, 1);

    // Reset in the middle of ISSUE.
    ack_en = 1'b0;
    req0 = 1'b1; data0 = 8'h42;
    step();
    chk("mid_tx_req", tx_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_req", tx_req, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    ack_en = 1'b1;
    sb.push_back({2'b01, 8'h42});
    step();
    chk("mid_resend_req", tx_req, 1);
    chk("mid_resend_data", tx_data, 8'h42);
    wait_acks(11, "mid_acks");
    req0 = 1'b0;
    wait_idle("mid_idle");

`ifdef UART_TX_ARB_STATS_EN
    chk("stat_cnt0", cnt0, 1);
    chk("stat_cnt1", cnt1, 0);
    chk("stat_to", to_cnt, 0);
`endif
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
